// File: rtl/req_ack_rr.sv
// Multi-channel request/acknowledge responder: edge-detected requests are held as pending bits,
// served round-robin, and each one is answered with a one-cycle ack after a programmable delay.
module req_ack_rr #(
  parameter int NCH   = 4,
  parameter int DLY_W = 4,
  localparam int IDX_W = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   req,
  input  logic [DLY_W-1:0] cfg_dly,
  input  logic [NCH-1:0]   ovf_clr,
  output logic [NCH-1:0]   ack,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             busy,
  output logic [NCH-1:0]   pend,
  output logic [NCH-1:0]   ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [NCH-1:0]   ONE_NCH  = {{(NCH-1){1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
  localparam logic [IDX_W:0]   NCH_EXT  = (IDX_W+1)'(NCH);

  state_t             state_r, state_nx_s;
  logic [DLY_W-1:0]   cnt_r, cnt_nx_s;
  logic [IDX_W-1:0]   gnt_idx_r, gnt_nx_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_nx_s;
  logic [NCH-1:0]     req_q_r, pend_r, ovf_r, ack_r;
  logic               busy_r;
  logic [NCH-1:0]     evt_s, ack_mask_s, pend_nx_s, ovf_nx_s, ack_nx_s;
  logic [2*NCH-1:0]   rot_s;
  logic [IDX_W-1:0]   sel_s;
  logic [IDX_W:0]     sum_s;
  logic               found_s, hit_s;

  assign evt_s      = req & ~req_q_r;
  assign ack_mask_s = (state_r == ACK) ? (ONE_NCH << gnt_idx_r) : {NCH{1'b0}};

  // Round-robin pick: rotate pending bits so rr_ptr lands at bit 0, take the lowest set bit.
  always_comb begin
    rot_s   = {pend_r, pend_r} >> rr_ptr_r;
    sel_s   = {IDX_W{1'b0}};
    found_s = 1'b0;
    sum_s   = {(IDX_W+1){1'b0}};
    hit_s   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      hit_s   = ~found_s & rot_s[k];
      sum_s   = {1'b0, rr_ptr_r} + (IDX_W+1)'(k);
      sum_s   = (sum_s >= NCH_EXT) ? (sum_s - NCH_EXT) : sum_s;
      sel_s   = hit_s ? sum_s[IDX_W-1:0] : sel_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state, counter, grant and pointer logic; output flops are loaded from the next state.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    gnt_nx_s   = gnt_idx_r;
    rr_nx_s    = rr_ptr_r;
    case (state_r)
      IDLE: begin
        if (|pend_r) begin
          gnt_nx_s   = sel_s;
          cnt_nx_s   = cfg_dly;
          state_nx_s = (cfg_dly == {DLY_W{1'b0}}) ? ACK : WAIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nx_s = cnt_r - DLY_W'(1);
        if (cnt_r == DLY_W'(1)) begin
          state_nx_s = ACK;
        end else begin
          state_nx_s = WAIT;
        end
      end
      ACK: begin
        state_nx_s = IDLE;
        rr_nx_s    = (gnt_idx_r == LAST_IDX) ? {IDX_W{1'b0}} : (gnt_idx_r + IDX_W'(1));
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    // A new request edge beats both the ACK-exit clear and the overflow clear.
    pend_nx_s = (pend_r & ~ack_mask_s) | evt_s;
    ovf_nx_s  = (ovf_r & ~ovf_clr) | (evt_s & pend_r & ~ack_mask_s);
    ack_nx_s  = (state_nx_s == ACK) ? (ONE_NCH << gnt_nx_s) : {NCH{1'b0}};
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {DLY_W{1'b0}};
      gnt_idx_r <= {IDX_W{1'b0}};
      rr_ptr_r  <= {IDX_W{1'b0}};
      req_q_r   <= {NCH{1'b0}};
      pend_r    <= {NCH{1'b0}};
      ovf_r     <= {NCH{1'b0}};
      ack_r     <= {NCH{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      gnt_idx_r <= gnt_nx_s;
      rr_ptr_r  <= rr_nx_s;
      req_q_r   <= req;
      pend_r    <= pend_nx_s;
      ovf_r     <= ovf_nx_s;
      ack_r     <= ack_nx_s;
      busy_r    <= (state_nx_s != IDLE);
    end
  end

  assign ack     = ack_r;
  assign gnt_idx = gnt_idx_r;
  assign busy    = busy_r;
  assign pend    = pend_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_req_ack_rr.sv
// Self-checking bench for req_ack_rr: directed scenarios plus randomized traffic, all checked
// against a transaction/timestamp reference model.
module tb_req_ack_rr;
  localparam int NCH   = 4;
  localparam int DLY_W = 4;
  localparam int IDX_W = 2;
  localparam int VW    = 2*NCH + 1 + IDX_W + 2*NCH - NCH;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   req, ovf_clr, ack, pend, ovf;
  logic [DLY_W-1:0] cfg_dly;
  logic [IDX_W-1:0] gnt_idx;
  logic             busy;

  int n_run = 0;
  int n_fail = 0;

  // Reference model: pending/overflow sets, rr pointer, and the timestamp of the next ack.
  logic [NCH-1:0] m_reqq = '0, m_pend = '0, m_ovf = '0;
  int  m_rr = 0, m_gnt = 0, m_ack_at = 0, cyc = 0;
  bit  m_txn = 1'b0;

  req_ack_rr #(.NCH(NCH), .DLY_W(DLY_W)) dut (
    .clk(clk), .rst(rst), .req(req), .cfg_dly(cfg_dly), .ovf_clr(ovf_clr),
    .ack(ack), .gnt_idx(gnt_idx), .busy(busy), .pend(pend), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] m_ack();
    return (m_txn && cyc == m_ack_at) ? (NCH'(1) << m_gnt) : '0;
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [IDX_W-1:0] g;
    g = m_gnt[IDX_W-1:0];
    return {m_ack(), m_txn, g, m_pend, m_ovf};
  endfunction

  task automatic model_edge();
    logic [NCH-1:0] evt, am;
    if (rst) begin
      m_reqq = '0; m_pend = '0; m_ovf = '0;
      m_rr = 0; m_gnt = 0; m_txn = 1'b0;
    end else begin
      evt = req & ~m_reqq;
      am  = m_ack();
      m_ovf = (m_ovf & ~ovf_clr) | (evt & m_pend & ~am);
      if (am != '0) begin
        m_rr  = (m_gnt + 1) % NCH;
        m_txn = 1'b0;
      end else if (!m_txn && m_pend != '0) begin
        for (int k = 0; k < NCH; k++) begin
          if (m_pend[(m_rr + k) % NCH]) begin
            m_gnt = (m_rr + k) % NCH;
            break;
          end
        end
        m_txn    = 1'b1;
        m_ack_at = cyc + 1 + int'(cfg_dly);
      end
      m_pend = (m_pend & ~am) | evt;
      m_reqq = req;
    end
    cyc++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ovf_clr = '0; cfg_dly = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1011; ovf_clr = '0; cfg_dly = 4'd3;
    tick(); tick();
    n_run++;
    if ({ack, busy, gnt_idx, pend, ovf} !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {ack, busy, gnt_idx, pend, ovf});
    end
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      req = (k == 0) ? 4'b0100 : 4'b0000;
      tick();
      n_run++;
      if ({ack, busy, gnt_idx, pend, ovf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_model c%0d: got %h want %h", k+1, {ack, busy, gnt_idx, pend, ovf}, exp_vec());
      end
      n_run++;
      if ({ack, pend[2], ovf} !== {((k+1 == 2) ? 4'b0100 : 4'b0000), (k+1 == 1 || k+1 == 2), 4'b0000}) begin
        n_fail++;
        $display("FAIL single_timing c%0d: ack=%b pend2=%b ovf=%b", k+1, ack, pend[2], ovf);
      end
    end
  endtask

  task automatic test_delay();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      req = 4'b0001;
      cfg_dly = (k < 3) ? 4'd5 : 4'd1;
      tick();
      n_run++;
      if ({ack, busy, gnt_idx, pend, ovf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL delay_model c%0d: got %h want %h", k+1, {ack, busy, gnt_idx, pend, ovf}, exp_vec());
      end
      n_run++;
      if (ack !== ((k+1 == 7) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL delay_ack c%0d: got %b", k+1, ack);
      end
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    logic [NCH-1:0] want;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      req = (k == 2) ? 4'b1110 : 4'b1111;
      tick();
      case (k + 1)
        2: want = 4'b0001;
        4: want = 4'b0010;
        6: want = 4'b0100;
        8: want = 4'b1000;
        10: want = 4'b0001;
        default: want = 4'b0000;
      endcase
      n_run++;
      if (ack !== want) begin
        n_fail++;
        $display("FAIL rr_ack c%0d: got %b want %b", k+1, ack, want);
      end
      n_run++;
      if ({ack, busy, gnt_idx, pend, ovf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL rr_model c%0d: got %h want %h", k+1, {ack, busy, gnt_idx, pend, ovf}, exp_vec());
      end
    end
    req = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    cfg_dly = 4'd8;
    for (int k = 0; k < 24; k++) begin
      req[1]  = (k <= 1) || (k == 4) || (k == 5) || (k == 12) || (k == 14);
      ovf_clr = (k == 14 || k == 16) ? 4'b0010 : 4'b0000;
      tick();
      n_run++;
      if ({ack, ovf} !== {((k+1 == 10 || k+1 == 22) ? 4'b0010 : 4'b0000),
                          ((k+1 >= 5 && k+1 <= 16) ? 4'b0010 : 4'b0000)}) begin
        n_fail++;
        $display("FAIL ovf_flags c%0d: ack=%b ovf=%b", k+1, ack, ovf);
      end
      n_run++;
      if ({ack, busy, gnt_idx, pend, ovf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL ovf_model c%0d: got %h want %h", k+1, {ack, busy, gnt_idx, pend, ovf}, exp_vec());
      end
    end
    req = '0; ovf_clr = '0;
  endtask

  task automatic test_set_wins();
    do_reset();
    for (int k = 0; k < 7; k++) begin
      req = (k == 0 || k == 2) ? 4'b1000 : 4'b0000;
      tick();
      n_run++;
      if ({ack, ovf} !== {((k+1 == 2 || k+1 == 4) ? 4'b1000 : 4'b0000), 4'b0000}) begin
        n_fail++;
        $display("FAIL setwins_ack c%0d: ack=%b ovf=%b", k+1, ack, ovf);
      end
      n_run++;
      if (k+1 == 3 && pend[3] !== 1'b1) begin
        n_fail++;
        $display("FAIL setwins_pend c3: got %b want 1", pend[3]);
      end
      n_run++;
      if ({ack, busy, gnt_idx, pend, ovf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL setwins_model c%0d: got %h want %h", k+1, {ack, busy, gnt_idx, pend, ovf}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cfg_dly = 4'd6;
    for (int k = 0; k < 18; k++) begin
      req = 4'b0010;
      rst = (k == 4 || k == 5);
      tick();
      n_run++;
      if (ack !== ((k+1 == 14) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL rstmid_ack c%0d: got %b", k+1, ack);
      end
      n_run++;
      if ((k+1 == 5 || k+1 == 6) && {ack, busy, gnt_idx, pend, ovf} !== {VW{1'b0}}) begin
        n_fail++;
        $display("FAIL rstmid_zero c%0d: got %h want 0", k+1, {ack, busy, gnt_idx, pend, ovf});
      end
      n_run++;
      if ({ack, busy, gnt_idx, pend, ovf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL rstmid_model c%0d: got %h want %h", k+1, {ack, busy, gnt_idx, pend, ovf}, exp_vec());
      end
    end
    rst = 1'b0; req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      req     = req ^ NCH'($urandom & $urandom);
      cfg_dly = ($urandom_range(0, 9) == 0) ? 4'd15 : DLY_W'($urandom_range(0, 3));
      ovf_clr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : 4'b0000;
      rst     = ($urandom_range(0, 499) == 0);
      tick();
      n_run++;
      if ({ack, busy, gnt_idx, pend, ovf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random_model k%0d: got %h want %h", k, {ack, busy, gnt_idx, pend, ovf}, exp_vec());
      end
      n_run++;
      if ($countones(ack) > 1) begin
        n_fail++;
        $display("FAIL random_onehot k%0d: ack=%b want at most one bit", k, ack);
      end
    end
    rst = 1'b0; req = '0; ovf_clr = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; ovf_clr = '0; cfg_dly = '0;
    #1;
    test_reset();
    test_single();
    test_delay();
    test_round_robin();
    test_overflow();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
